// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, I2S receiver states and
// channel-select encoding.
package audio_pkg;

    localparam int AUDIO_WIDTH = 24;

    typedef enum logic [1:0] {
        ALIGN,
        DELAY,
        SHIFT,
        HOLD
    } i2s_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit multi-flop synchroniser for pins asynchronous to clk.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/audio_i2s_rx.sv
// I2S ADC receiver: synchronises the codec pins, deserialises left/right
// slots and presents each completed stereo pair with a one-cycle en strobe.
module audio_i2s_rx
    import audio_pkg::*;
#(
    parameter int WIDTH       = AUDIO_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bclk,
    input  logic             lrclk,
    input  logic             adcdat,
    output logic [WIDTH-1:0] dataL,
    output logic [WIDTH-1:0] dataR,
    output logic             en,
    output logic             frame_err
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic bclk_s, lr_s, dat_s;
    logic bclk_d, lr_prev;
    logic brise, lr_chg, lr_fall;

    i2s_state_t       state, state_n;
    logic [WIDTH-1:0] sh, hold, sh_n, base_sh, word;
    logic [CW-1:0]    cnt, cnt_n, base_cnt;
    logic             ch, left_ok;
    logic             do_shift, do_commit, short_slot, ch_load;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_bclk (.clk(clk), .rst(rst), .d(bclk),   .q(bclk_s));
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_lr   (.clk(clk), .rst(rst), .d(lrclk),  .q(lr_s));
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_dat  (.clk(clk), .rst(rst), .d(adcdat), .q(dat_s));

    assign brise   = bclk_s & ~bclk_d;
    assign lr_chg  = brise & (lr_s ^ lr_prev);
    assign lr_fall = lr_chg & lr_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ALIGN;
        end else begin
            state <= state_n;
        end
    end

    // The rise that sees an lrclk change also carries the last bit of the
    // outgoing slot, so short slots include it before committing.
    always_comb begin
        state_n    = state;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        short_slot = 1'b0;
        ch_load    = 1'b0;
        base_sh    = (state == DELAY) ? '0 : sh;
        base_cnt   = (state == DELAY) ? '0 : cnt;
        sh_n       = {base_sh[WIDTH-2:0], dat_s};
        cnt_n      = base_cnt + 1'b1;
        if (brise) begin
            case (state)
                ALIGN: begin
                    if (lr_fall) begin
                        state_n = DELAY;
                        ch_load = 1'b1;
                    end
                end
                DELAY: begin
                    if (lr_chg) begin
                        ch_load = 1'b1;
                    end else begin
                        do_shift = 1'b1;
                        if (cnt_n == FULL) begin
                            do_commit = 1'b1;
                            state_n   = HOLD;
                        end else begin
                            state_n = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    do_shift = 1'b1;
                    if (lr_chg) begin
                        do_commit  = 1'b1;
                        short_slot = (cnt_n < FULL);
                        ch_load    = 1'b1;
                        state_n    = DELAY;
                    end else if (cnt_n == FULL) begin
                        do_commit = 1'b1;
                        state_n   = HOLD;
                    end
                end
                HOLD: begin
                    if (lr_chg) begin
                        ch_load = 1'b1;
                        state_n = DELAY;
                    end
                end
                default: state_n = ALIGN;
            endcase
        end
        word = short_slot ? (sh_n << (FULL - cnt_n)) : sh_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_d    <= 1'b0;
            lr_prev   <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            hold      <= '0;
            ch        <= CH_LEFT;
            left_ok   <= 1'b0;
            dataL     <= '0;
            dataR     <= '0;
            en        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bclk_d    <= bclk_s;
            en        <= 1'b0;
            frame_err <= 1'b0;
            if (brise) begin
                lr_prev <= lr_s;
            end
            if (ch_load) begin
                ch <= lr_s;
            end
            if (do_shift) begin
                sh  <= sh_n;
                cnt <= cnt_n;
            end
            // A right word only publishes when a left word of the same frame is held.
            if (do_commit) begin
                frame_err <= short_slot;
                if (ch == CH_LEFT) begin
                    hold    <= word;
                    left_ok <= 1'b1;
                end else begin
                    if (left_ok) begin
                        dataL <= hold;
                        dataR <= word;
                        en    <= 1'b1;
                    end
                    left_ok <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Scoreboard bench for audio_i2s_rx: I2S frames are serialised from word
// tables and random data; a monitor compares each en pulse with the queue.
module tb_audio_i2s_rx;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b1;
    logic        adcdat = 1'b0;
    logic [23:0] dataL, dataR;
    logic        en, frame_err;

    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    pair_t       expq[$];
    pair_t       mon_p;
    logic        dprev = 1'b0;
    logic        stable_bad = 1'b0;
    logic [23:0] lastL = '0, lastR = '0;
    int          sizes[5] = '{16, 20, 24, 25, 32};

    audio_i2s_rx #(.WIDTH(24), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .adcdat(adcdat),
        .dataL(dataL), .dataR(dataR), .en(en), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected capture: the first 24 bits of the slot, zero-filled if the slot is shorter.
    function automatic logic [23:0] model_word(input logic [31:0] b, input int n);
        logic [23:0] w;
        w = b[31:8];
        if (n < 24) w = w & ~(24'hFFFFFF >> n);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            lastL = '0;
            lastR = '0;
        end else begin
            if (frame_err === 1'b1) err_seen++;
            if (en === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_en actual dataL=%h dataR=%h required no pulse", dataL, dataR);
                end else begin
                    mon_p = expq.pop_front();
                    check("dataL", {8'h0, dataL}, {8'h0, mon_p.l});
                    check("dataR", {8'h0, dataR}, {8'h0, mon_p.r});
                end
                lastL = dataL;
                lastR = dataR;
            end else if (dataL !== lastL || dataR !== lastR) begin
                stable_bad = 1'b1;
            end
        end
    end

    // One bclk period; lrclk and data change on the falling edge, data lags lrclk by one bit.
    task automatic send_slot(input logic lr, input logic [31:0] b, input int n,
                             input int stall_at, input int rst_at);
        for (int i = 0; i < n; i++) begin
            bclk   = 1'b0;
            lrclk  = lr;
            adcdat = dprev;
            if (i == stall_at) begin
                for (int t = 0; t < 10; t++) begin
                    repeat (10) @(negedge clk);
                    lrclk = ~lrclk;
                end
            end
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            if (i == rst_at) begin
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("abort_dataL", {8'h0, dataL}, 32'h0);
                check("abort_dataR", {8'h0, dataR}, 32'h0);
                check("abort_en", {31'h0, en}, 32'h0);
                rst = 1'b1;
                return;
            end
            repeat (4) @(negedge clk);
            dprev = b[31-i];
        end
    endtask

    task automatic send_frame(input logic [31:0] bl, input int nl,
                              input logic [31:0] br, input int nr);
        pair_t p;
        p.l = model_word(bl, nl);
        p.r = model_word(br, nr);
        expq.push_back(p);
        if (nl < 24) err_exp++;
        if (nr < 24) err_exp++;
        send_slot(1'b0, bl, nl, -1, -1);
        send_slot(1'b1, br, nr, -1, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dataL", {8'h0, dataL}, 32'h0);
        check("rst_dataR", {8'h0, dataR}, 32'h0);
        check("rst_en", {31'h0, en}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic preamble(input int n);
        send_slot(1'b1, $urandom, n, -1, -1);
    endtask

    task automatic finish_test(input string name);
        send_slot(1'b0, $urandom, 4, -1, -1);
        for (int k = 0; k < 400 && expq.size() != 0; k++) @(negedge clk);
        check({name, "_pending_pairs"}, expq.size(), 0);
        expq.delete();
        check({name, "_frame_err_count"}, err_seen, err_exp);
        check({name, "_outputs_stable"}, {31'h0, stable_bad}, 32'h0);
        err_seen   = 0;
        err_exp    = 0;
        stable_bad = 1'b0;
    endtask

    initial begin
        // Directed 32-bit slot frame
        do_reset();
        preamble(6);
        send_frame({24'h123456, 8'($urandom)}, 32, {24'hABCDEF, 8'($urandom)}, 32);
        finish_test("single");

        // Back-to-back frames
        do_reset();
        preamble(6);
        send_frame({24'h000001, 8'hFF}, 32, {24'h800000, 8'hFF}, 32);
        send_frame({24'hFFFFFF, 8'h00}, 32, {24'h7FFFFF, 8'h00}, 32);
        send_frame({24'h5A5A5A, 8'($urandom)}, 32, {24'hA5A5A5, 8'($urandom)}, 32);
        finish_test("three");

        // 16-bit slots
        do_reset();
        preamble(6);
        send_frame({16'hBEEF, 16'hFFFF}, 16, {16'hCAFE, 16'hFFFF}, 16);
        finish_test("short16");

        // Reset released mid right word with lrclk high
        do_reset();
        send_slot(1'b1, $urandom, 8, -1, -1);
        do_reset();
        send_slot(1'b1, $urandom, 12, -1, -1);
        send_frame({24'h13579B, 8'h0}, 32, {24'h2468AC, 8'h0}, 32);
        finish_test("rel_mid_right");

        // Reset during the 10th right bit
        do_reset();
        preamble(6);
        send_frame({24'h111111, 8'h0}, 32, {24'h222222, 8'h0}, 32);
        send_slot(1'b0, {24'h333333, 8'h0}, 32, -1, -1);
        send_slot(1'b1, {24'h444444, 8'h0}, 32, -1, 10);
        preamble(6);
        send_frame({24'h00F00D, 8'h0}, 32, {24'h0BEEF0, 8'h0}, 32);
        finish_test("rst_mid_right");

        // bclk stalled mid left word while lrclk toggles
        do_reset();
        preamble(6);
        begin
            pair_t p;
            p.l = 24'hC0FFEE;
            p.r = 24'h0DDBA1;
            expq.push_back(p);
            send_slot(1'b0, {24'hC0FFEE, 8'h5}, 32, 8, -1);
            send_slot(1'b1, {24'h0DDBA1, 8'h5}, 32, -1, -1);
        end
        finish_test("bclk_stall");

        // Random words and slot lengths
        do_reset();
        preamble(6);
        for (int f = 0; f < 16; f++) begin
            send_frame($urandom, sizes[$urandom_range(0, 4)],
                       $urandom, sizes[$urandom_range(0, 4)]);
        end
        finish_test("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
